mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access stage between the EX/MEM pipeline register and the register-file writeback.
//  - Consumes the EX/MEM register outputs.
//  - Runs loads and stores on a req/ack data-memory port.
//  - Resolves branch/jump redirects.
//  - Registers the writeback bundle (MEM/WB).
//  - Raises stall_o to freeze upstream stages while a memory access is outstanding.
// PARAMETERS
//  TIMEOUT  default 255  cycles to wait for dmem_ack before aborting with a bus error (1..255)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  MEM_valid      in   1   EX/MEM slot holds a real instruction
//  MEM_pc         in   32  instruction PC
//  MEM_alu_res    in   32  ALU result; effective address for loads/stores
//  MEM_br_alu_res in   32  PC+imm; branch/jal target, auipc value
//  MEM_imm        in   32  immediate; lui value
//  MEM_rs2_val    in   32  store data
//  MEM_inst       in   32  raw instruction; funct3=[14:12], rd=[11:7], opcode=[6:0]
//  MEM_cmp_res    in   1   branch condition true
//  MEM_is_jal, MEM_is_jalr, MEM_is_auipc, MEM_is_lui, MEM_is_branch  in 1 each  decode flags
//  MEM_mem2reg    in   1   load
//  MEM_reg_wen    in   1   instruction writes rd
//  dmem_req       out  1   access request
//  dmem_we        out  1   1 = store
//  dmem_addr      out  32  word address {MEM_alu_res[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-aligned store data
//  dmem_rdata     in   32  read data, valid with dmem_ack
//  dmem_ack       in   1   access complete, 1-cycle pulse
//  stall_o        out  1   hold EX/MEM and earlier stages this cycle
//  redirect       out  1   redirect fetch this cycle
//  redirect_pc    out  32  redirect target
//  WB_valid       out  1   writeback slot valid
//  WB_reg_wen     out  1   write rd; forced 0 if rd==0 or on error
//  WB_rd          out  5   destination register
//  WB_wdata       out  32  writeback value
//  WB_pc          out  32  retired PC
//  WB_misalign    out  1   access was misaligned and suppressed
//  WB_bus_err     out  1   access timed out
// BEHAVIOUR
//  Reset: every WB_* output is 0; state=IDLE; timeout counter=0.
//    Combinational outputs are 0 while rst is high.
//  Op types: mem op = MEM_valid & (MEM_mem2reg | opcode==7'b0100011).
//  Alignment: misaligned = half access with addr[0]=1, or word access with addr[1:0]!=0.
//    A misaligned op issues no request and retires next edge with WB_misalign=1, WB_reg_wen=0.
//  FSM: IDLE, WAIT.
//    IDLE, aligned mem op: dmem_req=1 combinationally.
//      ack in the same cycle -> retire; no stall.
//      no ack -> stall_o=1; go to WAIT; counter=1.
//    WAIT: dmem_req=1; payload stays stable because upstream is frozen; stall_o=1 until ack.
//      ack -> retire; stall_o=0 that cycle; go to IDLE.
//      counter==TIMEOUT without ack -> drop req; retire with WB_bus_err=1, WB_reg_wen=0; go to IDLE.
//  Stores:
//    SB: be=1<<addr[1:0]; rs2[7:0] replicated on all lanes.
//    SH: be=addr[1]?4'b1100:4'b0011; rs2[15:0] replicated.
//    SW: be=4'hF.
//  Loads: read data is shifted by addr[1:0]; sign/zero extension is chosen by funct3.
//    LB=000, LH=001, LW=010, LBU=100, LHU=101.
//  Writeback value priority:
//    jal|jalr -> pc+4; lui -> imm; auipc -> br_alu_res; load -> extended data; else alu_res.
//  Redirect: combinational, only when MEM_valid and not stalled.
//    branch&cmp_res -> br_alu_res; jal -> br_alu_res; jalr -> {alu_res[31:1],1'b0}.
//  Retire: the WB register loads the bundle on the edge ending the retire cycle; latency is 1 cycle.
//    No retire that cycle -> WB_valid<=0, while WB_rd/WB_wdata/WB_pc hold their previous values.
//    A stalled cycle never retires.
//  Reset mid-access: req drops immediately; FSM returns to IDLE; the instruction is discarded.
// TESTING
//  - lw at 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall_o high 3 cycles; next edge WB_valid=1, WB_wdata=0xDEADBEEF.
//  - lb at 0x103, rdata 0x80FFFFFF, ack same cycle -> no stall; WB_wdata=0xFFFFFF80. Same with lbu -> 0x00000080.
//  - sh at 0x202, rs2 0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, WB_reg_wen=0.
//  - lw at 0x101 -> no dmem_req; WB_misalign=1, WB_reg_wen=0, 1-cycle latency.
//  - TIMEOUT=4, no ack -> req high 4 cycles, then dropped; WB_bus_err=1; stall releases.
//  - jalr pc 0x40, alu_res 0x81 -> redirect=1, redirect_pc=0x80; WB_wdata=0x44. rst mid-WAIT -> req=0, WB_valid=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage: runs loads/stores on a req/ack data port, resolves redirects and
// registers the writeback bundle, stalling upstream while an access is outstanding.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_alu_res,
  input  logic [31:0] MEM_br_alu_res,
  input  logic [31:0] MEM_imm,
  input  logic [31:0] MEM_rs2_val,
  input  logic [31:0] MEM_inst,
  input  logic        MEM_cmp_res,
  input  logic        MEM_is_jal,
  input  logic        MEM_is_jalr,
  input  logic        MEM_is_auipc,
  input  logic        MEM_is_lui,
  input  logic        MEM_is_branch,
  input  logic        MEM_mem2reg,
  input  logic        MEM_reg_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        WB_valid,
  output logic        WB_reg_wen,
  output logic [4:0]  WB_rd,
  output logic [31:0] WB_wdata,
  output logic [31:0] WB_pc,
  output logic        WB_misalign,
  output logic        WB_bus_err
);

  typedef enum logic {StIdle, StWait} state_e;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  off;
  logic        is_store, mem_op, misalign, aligned_op;
  logic        req, stall, bus_err, retire;
  logic [31:0] shifted, load_val, wb_val;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic        unused_inst;

  logic        wb_valid_q, wb_reg_wen_q, wb_misalign_q, wb_bus_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_wdata_q, wb_pc_q;

  assign opcode      = MEM_inst[6:0];
  assign funct3      = MEM_inst[14:12];
  assign rd          = MEM_inst[11:7];
  assign off         = MEM_alu_res[1:0];
  assign unused_inst = ^MEM_inst[31:15];

  assign is_store   = (opcode == 7'b0100011);
  assign mem_op     = MEM_valid & (MEM_mem2reg | is_store);
  assign misalign   = mem_op & (((funct3[1:0] == 2'b01) & off[0]) |
                                ((funct3[1:0] == 2'b10) & (off != 2'b00)));
  assign aligned_op = mem_op & ~misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aligned_op) begin
          req = 1'b1;
          if (!dmem_ack) begin
            stall   = 1'b1;
            state_d = StWait;
            cnt_d   = 8'd1;
          end
        end
      end
      StWait: begin
        if (cnt_q == TimeoutCnt) begin
          // Give up: request dropped, instruction retires flagged as a bus error.
          bus_err = 1'b1;
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          req = 1'b1;
          if (dmem_ack) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign retire = MEM_valid & ~stall;

  always_comb begin
    shifted = dmem_rdata >> {off, 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << off;
        st_data = {4{MEM_rs2_val[7:0]}};
      end
      2'b01: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{MEM_rs2_val[15:0]}};
      end
      default: begin
        be      = 4'hF;
        st_data = MEM_rs2_val;
      end
    endcase
    if (MEM_is_jal || MEM_is_jalr) wb_val = MEM_pc + 32'd4;
    else if (MEM_is_lui)           wb_val = MEM_imm;
    else if (MEM_is_auipc)         wb_val = MEM_br_alu_res;
    else if (MEM_mem2reg)          wb_val = load_val;
    else                           wb_val = MEM_alu_res;
  end

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'b0;
    if (MEM_valid && !stall && !rst) begin
      if (MEM_is_jal) begin
        redirect    = 1'b1;
        redirect_pc = MEM_br_alu_res;
      end else if (MEM_is_jalr) begin
        redirect    = 1'b1;
        redirect_pc = {MEM_alu_res[31:1], 1'b0};
      end else if (MEM_is_branch && MEM_cmp_res) begin
        redirect    = 1'b1;
        redirect_pc = MEM_br_alu_res;
      end
    end
  end

  assign dmem_req   = req & ~rst;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = rst ? 32'b0 : {MEM_alu_res[31:2], 2'b00};
  assign dmem_be    = rst ? 4'b0 : be;
  assign dmem_wdata = rst ? 32'b0 : st_data;
  assign stall_o    = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      wb_valid_q    <= 1'b0;
      wb_reg_wen_q  <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_wdata_q    <= 32'd0;
      wb_pc_q       <= 32'd0;
      wb_misalign_q <= 1'b0;
      wb_bus_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (retire) begin
        wb_valid_q    <= 1'b1;
        wb_reg_wen_q  <= MEM_reg_wen & (rd != 5'd0) & ~misalign & ~bus_err;
        wb_rd_q       <= rd;
        wb_wdata_q    <= wb_val;
        wb_pc_q       <= MEM_pc;
        wb_misalign_q <= misalign;
        wb_bus_err_q  <= bus_err;
      end else begin
        wb_valid_q    <= 1'b0;
        wb_reg_wen_q  <= 1'b0;
        wb_misalign_q <= 1'b0;
        wb_bus_err_q  <= 1'b0;
      end
    end
  end

  assign WB_valid    = wb_valid_q;
  assign WB_reg_wen  = wb_reg_wen_q;
  assign WB_rd       = wb_rd_q;
  assign WB_wdata    = wb_wdata_q;
  assign WB_pc       = wb_pc_q;
  assign WB_misalign = wb_misalign_q;
  assign WB_bus_err  = wb_bus_err_q;

endmodule
